// File: rtl/ped_signal_ctrl_pkg.sv
// Shared definitions for the pedestrian crossing controller.
// Light codes match the ones the upstream vehicle traffic-light FSM drives,
// so both blocks agree on what RED/YELLOW/GREEN mean on the 2-bit bus.
package ped_signal_ctrl_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_GREEN  = 2'd2;
  localparam logic [1:0] LIGHT_BAD    = 2'd3;

  localparam int DEF_WALK_LEN   = 16;
  localparam int DEF_CLEAR_LEN  = 8;
  localparam int DEF_BLINK_HALF = 2;
  localparam int DEF_CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2,
    FAULT = 2'd3
  } ped_state_e;

  // A light may hold its value or advance R->Y->G->R. Anything else,
  // including code 3 from any predecessor, is an illegal sequence.
  function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
    logic ok;
    ok = 1'b0;
    case (prev)
      LIGHT_RED:    ok = (cur == LIGHT_RED)    || (cur == LIGHT_YELLOW);
      LIGHT_YELLOW: ok = (cur == LIGHT_YELLOW) || (cur == LIGHT_GREEN);
      LIGHT_GREEN:  ok = (cur == LIGHT_GREEN)  || (cur == LIGHT_RED);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ped_signal_ctrl_light_seq_checker.sv
// light_seq_checker: watches the vehicle light code.
// Ports:
//   clk, rstn     - clock, asynchronous active-low reset
//   light_i       - vehicle light code this cycle
//   red_entry_o   - light is RED now and was not RED last cycle
//   illegal_o     - this cycle's light is not a legal successor of the last
// prev_light resets to RED, so the RED interval in progress at reset release
// never produces a red_entry strobe.
module light_seq_checker
  import ped_signal_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] light_i,
  output logic       red_entry_o,
  output logic       illegal_o
);

  logic [1:0] prev_light_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_light_q <= LIGHT_RED;
    end else begin
      prev_light_q <= light_i;
    end
  end

  assign red_entry_o = (light_i == LIGHT_RED) && (prev_light_q != LIGHT_RED);
  assign illegal_o   = !legal_step(prev_light_q, light_i);

endmodule

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian crossing controller downstream of the vehicle
// traffic-light FSM. Serves a latched push-button request with a steady WALK
// phase followed by a flashing CLEAR phase, both inside the vehicle RED.
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   light       - vehicle light code (0 RED, 1 YELLOW, 2 GREEN, 3 illegal)
//   ped_req     - push-button level
//   walk        - WALK lamp
//   dont_walk   - DONT_WALK lamp (flashes during CLEAR)
//   wait_lamp   - request pending
//   ped_ack     - one-cycle pulse when a request is latched
//   countdown   - cycles remaining in the crossing, 0 otherwise
//   abort       - one-cycle pulse when a crossing is cut short
//   fault       - sticky illegal light sequence flag
//   state_dbg   - current controller state (ped_state_e encoding)
// Request handshake: ped_req is a level sampled each cycle; in IDLE or CLEAR
// with nothing pending it is latched and ped_ack pulses on the next cycle.
// While a request is pending (or during WALK / FAULT) ped_req is ignored.
// All lamp/status outputs are registers loaded from the next-state decode.
module ped_signal_ctrl
  import ped_signal_ctrl_pkg::*;
#(
  parameter int WALK_LEN   = DEF_WALK_LEN,
  parameter int CLEAR_LEN  = DEF_CLEAR_LEN,
  parameter int BLINK_HALF = DEF_BLINK_HALF,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       light,
  input  logic             ped_req,
  output logic             walk,
  output logic             dont_walk,
  output logic             wait_lamp,
  output logic             ped_ack,
  output logic [CNT_W-1:0] countdown,
  output logic             abort,
  output logic             fault,
  output logic [1:0]       state_dbg
);

  localparam int BLK_W = $clog2(2 * BLINK_HALF);
  localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(WALK_LEN + CLEAR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_TO_CLEAR = CNT_W'(CLEAR_LEN);
  localparam logic [BLK_W-1:0] BLK_LAST     = BLK_W'(2 * BLINK_HALF - 1);
  localparam logic [BLK_W-1:0] BLK_HALF     = BLK_W'(BLINK_HALF);

  logic red_entry;
  logic illegal;

  light_seq_checker u_checker (
    .clk         (clk),
    .rstn        (rstn),
    .light_i     (light),
    .red_entry_o (red_entry),
    .illegal_o   (illegal)
  );

  ped_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blink_q, blink_d;
  logic             pending_q, pending_d;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic             ped_ack_q, ped_ack_d;
  logic [CNT_W-1:0] countdown_q, countdown_d;
  logic             abort_q, abort_d;
  logic             fault_q, fault_d;
  logic             latch;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      blink_q     <= '0;
      pending_q   <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      ped_ack_q   <= 1'b0;
      countdown_q <= '0;
      abort_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blink_q     <= blink_d;
      pending_q   <= pending_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      ped_ack_q   <= ped_ack_d;
      countdown_q <= countdown_d;
      abort_q     <= abort_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blink_d     = blink_q;
    pending_d   = pending_q;
    walk_d      = 1'b0;
    dont_walk_d = 1'b1;
    ped_ack_d   = 1'b0;
    countdown_d = '0;
    abort_d     = 1'b0;
    fault_d     = fault_q;

    latch = ped_req && !pending_q && ((state_q == IDLE) || (state_q == CLEAR));
    if (latch) begin
      pending_d = 1'b1;
      ped_ack_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A request latched on the RED-entry cycle itself is not yet in
        // pending_q, so it waits for the next RED entry.
        if (red_entry && pending_q) begin
          state_d   = WALK;
          pending_d = 1'b0;
          cnt_d     = CNT_LOAD;
        end
      end
      WALK: begin
        if (light != LIGHT_RED) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_TO_CLEAR) begin
            state_d = CLEAR;
            blink_d = '0;
          end
        end
      end
      CLEAR: begin
        if (light != LIGHT_RED) begin
          state_d = IDLE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          blink_d = (blink_q == BLK_LAST) ? '0 : blink_q + 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase

    // Fault wins over everything and is only left through rstn.
    if (illegal || (state_q == FAULT)) begin
      state_d   = FAULT;
      pending_d = 1'b0;
      ped_ack_d = 1'b0;
      abort_d   = 1'b0;
      cnt_d     = '0;
      fault_d   = 1'b1;
    end

    case (state_d)
      WALK: begin
        walk_d      = 1'b1;
        dont_walk_d = 1'b0;
        countdown_d = cnt_d;
      end
      CLEAR: begin
        dont_walk_d = (blink_d < BLK_HALF);
        countdown_d = cnt_d;
      end
      default: begin
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        countdown_d = '0;
      end
    endcase
  end

  assign walk      = walk_q;
  assign dont_walk = dont_walk_q;
  assign wait_lamp = pending_q;
  assign ped_ack   = ped_ack_q;
  assign countdown = countdown_q;
  assign abort     = abort_q;
  assign fault     = fault_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Bench for ped_signal_ctrl: a traffic-light generator drives the light bus,
// a crossing-age reference model predicts the output vector for every clock
// edge, and a negedge monitor pops and compares.
module tb_ped_signal_ctrl;

  localparam int WALK_LEN   = 16;
  localparam int CLEAR_LEN  = 8;
  localparam int BLINK_HALF = 2;
  localparam int TOTAL      = WALK_LEN + CLEAR_LEN;
  localparam int W          = 11;

  // Packed order: {walk, dont_walk, wait_lamp, ped_ack, abort, fault, countdown[4:0]}
  localparam logic [W-1:0] RESET_VEC = 11'b01000_000000;
  localparam logic [W-1:0] FAULT_VEC = 11'b01000_100000;

  logic       clk;
  logic       rstn;
  logic [1:0] light;
  logic       ped_req;
  logic       walk, dont_walk, wait_lamp, ped_ack, abort, fault;
  logic [4:0] countdown;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  ped_signal_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .light     (light),
    .ped_req   (ped_req),
    .walk      (walk),
    .dont_walk (dont_walk),
    .wait_lamp (wait_lamp),
    .ped_ack   (ped_ack),
    .countdown (countdown),
    .abort     (abort),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] pack_dut();
    return {walk, dont_walk, wait_lamp, ped_ack, abort, fault, countdown};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%b exp=%b (w,dw,wait,ack,abort,fault,cd)", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the crossing as an age (cycles since WALK started) instead of a
  // state machine; lamps and countdown are derived from the age arithmetically.
  logic [1:0] m_prev;
  bit         m_fault;
  bit         m_pending;
  int         m_age;

  initial begin
    bit red_entry, bad, crossing, in_walk, latch, ack, abrt, w, dw;
    logic [4:0] cd;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_prev = 2'd0; m_fault = 0; m_pending = 0; m_age = -1;
      end else begin
        red_entry = (light == 2'd0) && (m_prev != 2'd0);
        bad = (light == 2'd3) ||
              ((light != m_prev) && (int'(light) != (int'(m_prev) + 1) % 3));
        ack = 0; abrt = 0;
        if (m_fault || bad) begin
          m_fault = 1; m_pending = 0; m_age = -1;
        end else begin
          crossing = (m_age >= 0);
          in_walk  = crossing && (m_age < WALK_LEN);
          latch    = !in_walk && ped_req && !m_pending;
          if (crossing && light != 2'd0) begin
            abrt = 1; m_age = -1;
          end else if (crossing) begin
            m_age++;
            if (m_age == TOTAL) m_age = -1;
          end else if (red_entry && m_pending) begin
            m_age = 0; m_pending = 0;
          end
          if (latch) begin
            m_pending = 1; ack = 1;
          end
        end
        m_prev = light;
        if (m_fault) begin
          exp_q.push_back(FAULT_VEC);
        end else begin
          if (m_age >= 0) begin
            cd = 5'(TOTAL - 1 - m_age);
            w  = (m_age < WALK_LEN);
            dw = w ? 1'b0 : ((((m_age - WALK_LEN) / BLINK_HALF) % 2) == 0);
          end else begin
            cd = 5'd0; w = 0; dw = 1;
          end
          exp_q.push_back({w, dw, m_pending, ack, abrt, 1'b0, cd});
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] act, exp;
    forever begin
      @(negedge clk);
      act = pack_dut();
      if (!rstn) begin
        check("reset_hold", act, RESET_VEC);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow t=%0t act=%b exp=<queue empty>", $time, act);
      end else begin
        exp = exp_q.pop_front();
        check("sb_out", act, exp);
      end
    end
  end

  // ---------------- drivers ----------------
  int tl_ph;
  int tl_left;

  function automatic int dur(input int ph);
    case (ph)
      0:       return 30;
      1:       return 5;
      default: return 20;
    endcase
  endfunction

  task automatic set_phase(input int ph);
    tl_ph   = ph;
    tl_left = dur(ph);
  endtask

  task automatic drive_cycle(input logic [1:0] l, input logic r);
    @(posedge clk);
    #1;
    light   = l;
    ped_req = r;
  endtask

  task automatic tl_tick(input logic r);
    drive_cycle(2'(tl_ph), r);
    tl_left--;
    if (tl_left == 0) set_phase((tl_ph + 1) % 3);
  endtask

  // Runs the light generator until the next tick is the first of phase ph.
  task automatic goto_phase(input int ph);
    for (int i = 0; i < 80; i++) begin
      if (tl_ph == ph && tl_left == dur(ph)) break;
      tl_tick(1'b0);
    end
  endtask

  task automatic do_reset(input logic check_now);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    exp_q.delete();
    light   = 2'd0;
    ped_req = 1'b0;
    #1;
    if (check_now) check("reset_async", pack_dut(), RESET_VEC);
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    light   = 2'd0;
    ped_req = 1'b0;
    rstn    = 1'b1;
    set_phase(0);
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;

    // Two full light cycles without a request.
    repeat (110) tl_tick(1'b0);

    // Request pulse during GREEN, full crossing in the following RED.
    goto_phase(2);
    repeat (3) tl_tick(1'b0);
    tl_tick(1'b1);
    goto_phase(0);
    repeat (40) tl_tick(1'b0);

    // Request on the exact RED-entry cycle: served one RED later.
    goto_phase(2);
    goto_phase(0);
    tl_tick(1'b1);
    repeat (100) tl_tick(1'b0);

    // Abort five cycles into WALK.
    goto_phase(2);
    tl_tick(1'b1);
    goto_phase(0);
    repeat (6) tl_tick(1'b0);
    set_phase(1);
    repeat (10) tl_tick(1'b0);

    // Abort during CLEAR with a request latched in CLEAR; it stays pending.
    goto_phase(2);
    tl_tick(1'b1);
    goto_phase(0);
    repeat (19) tl_tick(1'b0);
    tl_tick(1'b1);
    tl_tick(1'b0);
    set_phase(1);
    goto_phase(0);
    repeat (30) tl_tick(1'b0);

    // Randomised traffic with random presses and occasional early YELLOW.
    for (int i = 0; i < 600; i++) begin
      if (tl_ph == 0 && $urandom_range(0, 63) == 0) set_phase(1);
      tl_tick(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    // Reset in the middle of CLEAR; the RED in progress is not served.
    goto_phase(2);
    tl_tick(1'b1);
    goto_phase(0);
    repeat (20) tl_tick(1'b0);
    do_reset(1'b1);
    tl_tick(1'b1);
    goto_phase(0);
    repeat (30) tl_tick(1'b0);

    // Illegal GREEN->YELLOW: sticky fault, later presses ignored.
    goto_phase(2);
    repeat (4) tl_tick(1'b0);
    set_phase(1);
    repeat (3) tl_tick(1'b0);
    for (int i = 0; i < 80; i++) tl_tick((i % 20 == 0) ? 1'b1 : 1'b0);

    do_reset(1'b0);
    set_phase(0);

    // Illegal code 3 for one cycle.
    goto_phase(2);
    tl_tick(1'b1);
    repeat (5) tl_tick(1'b0);
    drive_cycle(2'd3, 1'b0);
    for (int i = 0; i < 100; i++) tl_tick(($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain act=%0d leftover exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
- Pedestrian crossing controller placed directly downstream of the vehicle traffic-light FSM.
- Consumes the FSM's 2-bit light code and a pedestrian push-button request.
- Grants a WALK phase, then a flashing CLEAR phase, inside the vehicle RED interval. Drives a remaining-time countdown.
- Checks the vehicle light sequence; an illegal sequence forces a permanent safe state.

Parameters:
- WALK_LEN, 16, cycles of steady WALK per granted crossing.
- CLEAR_LEN, 8, cycles of flashing DONT_WALK after WALK. WALK_LEN+CLEAR_LEN must be less than the vehicle RED duration (30).
- BLINK_HALF, 2, cycles per on or off half-period of the CLEAR flash.
- CNT_W, 5, countdown width. Must hold WALK_LEN+CLEAR_LEN-1.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- light  in  2  vehicle light code: 0=RED, 1=YELLOW, 2=GREEN, 3=illegal.
- ped_req  in  1  synchronous button level; high means request.
- walk  out  1  WALK lamp.
- dont_walk  out  1  DONT_WALK lamp.
- wait_lamp  out  1  request-pending indicator.
- ped_ack  out  1  one-cycle pulse when a request is first latched.
- countdown  out  CNT_W  cycles remaining in the crossing; 0 when not crossing.
- abort  out  1  one-cycle pulse when a crossing is cut short.
- fault  out  1  sticky illegal-sequence flag.

Behaviour:
- All outputs are registered. Clock and reset are fixed: one clock, clk; reset rstn is asynchronous and active-low.
- Reset values: state=IDLE, walk=0, dont_walk=1, wait_lamp=0, ped_ack=0, countdown=0, abort=0, fault=0, prev_light=RED, pending=0, cnt=0.
- prev_light registers light every cycle. RED entry is the cycle where light==RED and prev_light!=RED. Because prev_light resets to RED, the first RED interval after reset is never served.
- Request latch: in IDLE or CLEAR, ped_req=1 with pending=0 sets pending=1 and pulses ped_ack on the next cycle. ped_req in WALK is ignored. wait_lamp equals pending.
- State IDLE: walk=0, dont_walk=1.
  - On RED entry with pending=1: go to WALK, clear pending, load cnt=WALK_LEN+CLEAR_LEN-1. walk rises one cycle after light first reads RED.
  - A request arriving in the same cycle as RED entry, with pending=0, is not served. It is latched and served at the next RED entry.
- State WALK: walk=1, dont_walk=0, countdown=cnt, cnt decrements each cycle.
  - When cnt reaches CLEAR_LEN-1, go to CLEAR and reset the blink counter.
- State CLEAR: walk=0, countdown=cnt, cnt decrements each cycle.
  - dont_walk is 1 for BLINK_HALF cycles, then 0 for BLINK_HALF cycles, repeating from CLEAR entry.
  - When the cycle showing cnt==0 completes, go to IDLE with countdown=0.
- Abort: if light!=RED while in WALK or CLEAR, go to IDLE next cycle with walk=0, dont_walk=1, countdown=0, and pulse abort for 1 cycle. A request latched during CLEAR stays pending.
- Fault: set when light==3, or when light changes to a value other than R->Y, Y->G or G->R.
  - Takes effect next cycle and overrides everything: walk=0, dont_walk=1 steady, countdown=0, wait_lamp=0, no ped_ack or abort.
  - The FAULT state is exited only by rstn.
- Reset mid-crossing returns immediately, asynchronously, to the reset values.

Decomposition:
- Shared package: light codes RED/YELLOW/GREEN (the same constants the traffic-light FSM uses), the ped state enum IDLE/WALK/CLEAR/FAULT, and default lengths.
- One sub-module: light_seq_checker. It holds the prev_light register, outputs a red_entry strobe, and outputs an illegal-transition strobe.

Test Plan:
- Drive the real traffic-light FSM (RED 30 / YELLOW 5 / GREEN 20). Pulse ped_req during GREEN.
  - Required: ped_ack 1 cycle later; wait_lamp=1 until RED entry.
  - walk=1 for 16 cycles with countdown 23 down to 8.
  - CLEAR for 8 cycles with countdown 7 down to 0 and dont_walk pattern 1,1,0,0,1,1,0,0.
  - Then IDLE with dont_walk=1.
- No ped_req over two full light cycles -> walk stays 0, dont_walk stays 1, countdown stays 0.
- ped_req asserted on the exact RED-entry cycle -> no walk this RED; walk at the following RED entry.
- Force light=YELLOW 5 cycles into WALK -> next cycle walk=0, dont_walk=1, countdown=0; abort pulses exactly 1 cycle.
- Force GREEN->YELLOW, and separately light=3 -> fault=1 next cycle and stays high. Later requests give no ped_ack and no walk until rstn.
- Deassert rstn mid-CLEAR -> outputs show reset values immediately without a clock edge. The first RED after release is not served.
